gpio_register: RTL and testbench
================================

GPIO_REGISTER -- requirements
Module: gpio_register

Interface
REQ-001 SHALL have parameter: GPIO_W, 32, pad/register width; all 32-bit ports below are GPIO_W wide.
REQ-002 SHALL have one clock; reset is asynchronous and active-high: sys_clk  in  1  system clock, all state on rising edge.
REQ-003 sys_rst  in  1  asynchronous active-high reset.
REQ-004 gpio_we  in  1  write strobe, sampled on sys_clk rising edge.
REQ-005 gpio_addr  in  32  byte address; only bits [7:0] decoded.
REQ-006 gpio_dat_i  in  32  write data.
REQ-007 aux_i  in  32  auxiliary output sources.
REQ-008 in_pad_i  in  32  asynchronous input pads.
REQ-009 gpio_eclk  in  1  external sampling strobe, asynchronous, treated as data.
REQ-010 gpio_inta_o  out  1  interrupt request.
REQ-011 gpio_dat_o  out  32  read data.
REQ-012 out_pad_o  out  32  pad output values.
REQ-013 oen_padoe_o  out  32  pad output enables, 1 = drive.

Function
REQ-014 Register map: 0x00 IN (RO), 0x04 OUT, 0x08 OE, 0x0C INTE, 0x10 PTRIG, 0x14 AUX, 0x18 INTS, 0x1C ECLK, 0x20 NEC.
REQ-015 Write: gpio_we=1 at rising edge loads gpio_dat_i into addressed RW register; writes to IN or unmapped addresses are ignored.
REQ-016 Read: gpio_dat_o is combinational mux of addressed register, zero latency; unmapped addresses read 0.
REQ-017 out_pad_o = (OUT & ~AUX) | (aux_i & AUX), combinational, per bit.
REQ-018 oen_padoe_o = OE.
REQ-019 in_pad_i and gpio_eclk each pass through a 2-flop synchronizer; a third flop on synced eclk gives rise/fall strobes.
REQ-020 IN bit n loads synced pad bit every cycle when ECLK[n]=0; when ECLK[n]=1, loads only on synced eclk rising strobe (NEC[n]=0) or falling strobe (NEC[n]=1).
REQ-021 Pad change to IN update latency: 3 sys_clk edges in ECLK=0 mode.
REQ-022 Event bit n: IN[n] loads a value differing from current IN[n], with rising (0->1) if PTRIG[n]=1, falling (1->0) if PTRIG[n]=0.
REQ-023 INTS[n] sets on the same edge as event n when INTE[n]=1; sticky until cleared.
REQ-024 Write to INTS: INTS <= gpio_dat_i & INTS (write 0 clears, write 1 keeps); a same-cycle new event sets its bit (set wins).
REQ-025 gpio_inta_o = OR-reduction of INTS, driven from flops, no extra latency.
REQ-026 Disabling INTE[n] does not clear a pending INTS[n].

Reset
REQ-027 sys_rst=1 asynchronously clears all registers, synchronizer and edge flops to 0.
REQ-028 During/after reset: out_pad_o=0, oen_padoe_o=0, gpio_inta_o=0, gpio_dat_o=0 for any address.
REQ-029 Reset mid-operation aborts any pending write and clears pending interrupts immediately.

Structure
REQ-030 Shared package gpio_pkg holds GPIO_W default and all register address constants.
REQ-031 One sub-module gpio_sync (parameterized-width 2-flop synchronizer, async reset) instantiated for in_pad_i and gpio_eclk.

Verification
REQ-032 Write OUT=0xAAAAAAAA, read 0x04 -> gpio_dat_o=0xAAAAAAAA, out_pad_o=0xAAAAAAAA.
REQ-033 Write OE=0xFFFFFFFF -> oen_padoe_o=0xFFFFFFFF; write AUX=0xFFFFFFFF, aux_i=0x12345678 -> out_pad_o=0x12345678; AUX=0 -> 0xAAAAAAAA.
REQ-034 INTE=1, PTRIG=1, in_pad_i 0->1 -> INTS=0x1, gpio_inta_o=1 on 3rd edge; write INTS=0 -> gpio_inta_o=0 next edge.
REQ-035 INTE=1, PTRIG=0: rising pad -> no interrupt; falling pad -> INTS[0]=1.
REQ-036 ECLK=0x1, NEC=0: in_pad_i[0]=1 leaves IN[0]=0 until gpio_eclk rises; NEC=0x1 -> captures on eclk fall.
REQ-037 Assert sys_rst with INTS pending and OUT=0xAAAAAAAA -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register block: default width and the byte-address map.
package gpio_pkg;

  localparam int GPIO_W_DEFAULT = 32;

  localparam logic [7:0] ADDR_IN    = 8'h00;
  localparam logic [7:0] ADDR_OUT   = 8'h04;
  localparam logic [7:0] ADDR_OE    = 8'h08;
  localparam logic [7:0] ADDR_INTE  = 8'h0C;
  localparam logic [7:0] ADDR_PTRIG = 8'h10;
  localparam logic [7:0] ADDR_AUX   = 8'h14;
  localparam logic [7:0] ADDR_INTS  = 8'h18;
  localparam logic [7:0] ADDR_ECLK  = 8'h1C;
  localparam logic [7:0] ADDR_NEC   = 8'h20;

endpackage

// File: rtl/gpio_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
module gpio_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_register.sv
// GPIO register block: pad I/O, aux muxing, sampled inputs with optional external strobe,
// and sticky edge-triggered interrupts.
module gpio_register
  import gpio_pkg::*;
#(
  parameter int GPIO_W = GPIO_W_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              gpio_we,
  input  logic [GPIO_W-1:0] gpio_addr,
  input  logic [GPIO_W-1:0] gpio_dat_i,
  input  logic [GPIO_W-1:0] aux_i,
  input  logic [GPIO_W-1:0] in_pad_i,
  input  logic              gpio_eclk,
  output logic              gpio_inta_o,
  output logic [GPIO_W-1:0] gpio_dat_o,
  output logic [GPIO_W-1:0] out_pad_o,
  output logic [GPIO_W-1:0] oen_padoe_o
);

  // Bus protocol: no handshake. gpio_we is a single-cycle write strobe sampled at the
  // rising edge together with gpio_addr/gpio_dat_i; reads are a zero-latency mux.
  logic [7:0]        addr8;
  logic              unused_addr_bits;
  logic [GPIO_W-1:0] pad_sync;
  logic              eclk_sync;
  logic              eclk_d1_q;
  logic              eclk_rise;
  logic              eclk_fall;

  logic [GPIO_W-1:0] in_q, in_d;
  logic [GPIO_W-1:0] out_q, oe_q, inte_q, ptrig_q, aux_q, eclk_q, nec_q;
  logic [GPIO_W-1:0] ints_q, ints_d;
  logic [GPIO_W-1:0] in_load;
  logic [GPIO_W-1:0] in_event;
  logic              wr_ints;

  assign addr8            = gpio_addr[7:0];
  assign unused_addr_bits = ^gpio_addr[GPIO_W-1:8];

  gpio_sync #(.W(GPIO_W)) u_pad_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (in_pad_i),
    .q_o   (pad_sync)
  );

  gpio_sync #(.W(1)) u_eclk_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (gpio_eclk),
    .q_o   (eclk_sync)
  );

  assign eclk_rise = eclk_sync & ~eclk_d1_q;
  assign eclk_fall = ~eclk_sync & eclk_d1_q;
  assign wr_ints   = gpio_we && (addr8 == ADDR_INTS);

  // A bit samples every cycle unless its ECLK bit selects the external strobe edge.
  always_comb begin
    in_load  = ~eclk_q | ({GPIO_W{eclk_rise}} & ~nec_q) | ({GPIO_W{eclk_fall}} & nec_q);
    in_d     = (in_load & pad_sync) | (~in_load & in_q);
    in_event = (in_d ^ in_q) & ~(in_d ^ ptrig_q);
    ints_d   = wr_ints ? (gpio_dat_i & ints_q) : ints_q;
    ints_d   = ints_d | (in_event & inte_q);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      eclk_d1_q <= 1'b0;
      in_q      <= '0;
      ints_q    <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      inte_q    <= '0;
      ptrig_q   <= '0;
      aux_q     <= '0;
      eclk_q    <= '0;
      nec_q     <= '0;
    end else begin
      eclk_d1_q <= eclk_sync;
      in_q      <= in_d;
      ints_q    <= ints_d;
      if (gpio_we) begin
        case (addr8)
          ADDR_OUT:   out_q   <= gpio_dat_i;
          ADDR_OE:    oe_q    <= gpio_dat_i;
          ADDR_INTE:  inte_q  <= gpio_dat_i;
          ADDR_PTRIG: ptrig_q <= gpio_dat_i;
          ADDR_AUX:   aux_q   <= gpio_dat_i;
          ADDR_ECLK:  eclk_q  <= gpio_dat_i;
          ADDR_NEC:   nec_q   <= gpio_dat_i;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    gpio_dat_o = '0;
    case (addr8)
      ADDR_IN:    gpio_dat_o = in_q;
      ADDR_OUT:   gpio_dat_o = out_q;
      ADDR_OE:    gpio_dat_o = oe_q;
      ADDR_INTE:  gpio_dat_o = inte_q;
      ADDR_PTRIG: gpio_dat_o = ptrig_q;
      ADDR_AUX:   gpio_dat_o = aux_q;
      ADDR_INTS:  gpio_dat_o = ints_q;
      ADDR_ECLK:  gpio_dat_o = eclk_q;
      ADDR_NEC:   gpio_dat_o = nec_q;
      default:    gpio_dat_o = '0;
    endcase
  end

  assign out_pad_o   = (out_q & ~aux_q) | (aux_i & aux_q);
  assign oen_padoe_o = oe_q;
  assign gpio_inta_o = |ints_q;

endmodule

// File: tb/tb_gpio_register.sv
// Bench for gpio_register: directed register/interrupt/strobe scenarios, then randomized traffic
// checked against a history-based behavioural model.
module tb_gpio_register;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        gpio_we = 1'b0;
  logic [31:0] gpio_addr = '0;
  logic [31:0] gpio_dat_i = '0;
  logic [31:0] aux_i = '0;
  logic [31:0] in_pad_i = '0;
  logic        gpio_eclk = 1'b0;
  logic        gpio_inta_o;
  logic [31:0] gpio_dat_o;
  logic [31:0] out_pad_o;
  logic [31:0] oen_padoe_o;

  int checks = 0;
  int failures = 0;

  gpio_register #(.GPIO_W(32)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .gpio_we     (gpio_we),
    .gpio_addr   (gpio_addr),
    .gpio_dat_i  (gpio_dat_i),
    .aux_i       (aux_i),
    .in_pad_i    (in_pad_i),
    .gpio_eclk   (gpio_eclk),
    .gpio_inta_o (gpio_inta_o),
    .gpio_dat_o  (gpio_dat_o),
    .out_pad_o   (out_pad_o),
    .oen_padoe_o (oen_padoe_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: register file plus histories of the raw pad/strobe inputs.
  logic [31:0] m_in, m_out, m_oe, m_inte, m_ptrig, m_aux, m_ints, m_eclk, m_nec;
  logic [31:0] pad_h[$];
  logic        ecl_h[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_in, m_out, m_oe, m_inte, m_ptrig, m_aux, m_ints, m_eclk, m_nec} = '0;
    pad_h.delete();
    ecl_h.delete();
    for (int i = 0; i < 4; i++) begin
      pad_h.push_back('0);
      ecl_h.push_back(1'b0);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_in;
      8'h04: return m_out;
      8'h08: return m_oe;
      8'h0C: return m_inte;
      8'h10: return m_ptrig;
      8'h14: return m_aux;
      8'h18: return m_ints;
      8'h1C: return m_eclk;
      8'h20: return m_nec;
      default: return '0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present just before it.
  task automatic model_step();
    logic [31:0] cand, new_in;
    logic        er, ef, load, ev;
    logic [7:0]  a;
    pad_h.push_front(in_pad_i);
    ecl_h.push_front(gpio_eclk);
    while (pad_h.size() > 4) void'(pad_h.pop_back());
    while (ecl_h.size() > 4) void'(ecl_h.pop_back());
    // The register sees the pad value from two edges ago; strobe edges from the synced history.
    cand = pad_h[2];
    er   = ecl_h[2] && !ecl_h[3];
    ef   = !ecl_h[2] && ecl_h[3];
    a    = gpio_addr[7:0];
    new_in = m_in;
    if (gpio_we && a == 8'h18) m_ints = m_ints & gpio_dat_i;
    for (int n = 0; n < 32; n++) begin
      load = !m_eclk[n] || (m_nec[n] ? ef : er);
      if (load) new_in[n] = cand[n];
      ev = m_ptrig[n] ? (!m_in[n] && new_in[n]) : (m_in[n] && !new_in[n]);
      if (ev && m_inte[n]) m_ints[n] = 1'b1;
    end
    m_in = new_in;
    if (gpio_we) begin
      case (a)
        8'h04: m_out   = gpio_dat_i;
        8'h08: m_oe    = gpio_dat_i;
        8'h0C: m_inte  = gpio_dat_i;
        8'h10: m_ptrig = gpio_dat_i;
        8'h14: m_aux   = gpio_dat_i;
        8'h1C: m_eclk  = gpio_dat_i;
        8'h20: m_nec   = gpio_dat_i;
        default: ;
      endcase
    end
  endtask

  task automatic model_check();
    chk("m_dat", gpio_dat_o, m_read(gpio_addr[7:0]));
    chk("m_pad", out_pad_o, (m_out & ~m_aux) | (aux_i & m_aux));
    chk("m_oen", oen_padoe_o, m_oe);
    chk("m_inta", {31'b0, gpio_inta_o}, {31'b0, |m_ints});
  endtask

  task automatic cycle(input logic we, input logic [31:0] addr, input logic [31:0] dat);
    gpio_we    = we;
    gpio_addr  = addr;
    gpio_dat_i = dat;
    model_step();
    @(posedge sys_clk);
    #1;
    model_check();
  endtask

  task automatic idle(input int n, input logic [31:0] addr);
    for (int i = 0; i < n; i++) cycle(1'b0, addr, '0);
  endtask

  initial begin
    logic [31:0] r;
    // Reset state
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    gpio_addr = 32'h04; #1;
    chk("rst_dat_out", gpio_dat_o, 32'h0);
    gpio_addr = 32'h18; #1;
    chk("rst_dat_ints", gpio_dat_o, 32'h0);
    chk("rst_pad", out_pad_o, 32'h0);
    chk("rst_oen", oen_padoe_o, 32'h0);
    chk("rst_inta", {31'b0, gpio_inta_o}, 32'h0);
    sys_rst = 1'b0;
    model_reset();

    // Output register and readback
    cycle(1'b1, 32'h04, 32'hAAAAAAAA);
    chk("out_read", gpio_dat_o, 32'hAAAAAAAA);
    chk("out_pad", out_pad_o, 32'hAAAAAAAA);
    cycle(1'b1, 32'h00, 32'h5555_5555);
    chk("in_ro", gpio_dat_o, 32'h0);

    // Output enable and aux muxing
    cycle(1'b1, 32'h08, 32'hFFFFFFFF);
    chk("oe_pad", oen_padoe_o, 32'hFFFFFFFF);
    aux_i = 32'h12345678;
    cycle(1'b1, 32'h14, 32'hFFFFFFFF);
    chk("aux_on", out_pad_o, 32'h12345678);
    cycle(1'b1, 32'h14, 32'h0);
    chk("aux_off", out_pad_o, 32'hAAAAAAAA);

    // Rising-edge interrupt, 3-edge latency, clear by writing 0
    cycle(1'b1, 32'h0C, 32'h1);
    cycle(1'b1, 32'h10, 32'h1);
    idle(3, 32'h18);
    in_pad_i = 32'h1;
    idle(1, 32'h18);
    chk("int_e1", {31'b0, gpio_inta_o}, 32'h0);
    idle(1, 32'h18);
    chk("int_e2", {31'b0, gpio_inta_o}, 32'h0);
    idle(1, 32'h18);
    chk("int_e3", {31'b0, gpio_inta_o}, 32'h1);
    chk("ints_e3", gpio_dat_o, 32'h1);
    cycle(1'b1, 32'h18, 32'h0);
    chk("int_clr", {31'b0, gpio_inta_o}, 32'h0);

    // Falling-edge trigger: rising pad ignored, falling pad flags
    in_pad_i = 32'h0;
    idle(4, 32'h18);
    cycle(1'b1, 32'h10, 32'h0);
    in_pad_i = 32'h1;
    idle(4, 32'h18);
    chk("fall_rise_none", {31'b0, gpio_inta_o}, 32'h0);
    in_pad_i = 32'h0;
    idle(4, 32'h18);
    chk("fall_ints", gpio_dat_o, 32'h1);
    cycle(1'b1, 32'h18, 32'h0);

    // External strobe sampling: rising then falling edge of eclk
    cycle(1'b1, 32'h1C, 32'h1);
    in_pad_i = 32'h1;
    idle(5, 32'h00);
    chk("eclk_hold", gpio_dat_o, 32'h0);
    gpio_eclk = 1'b1;
    idle(2, 32'h00);
    chk("eclk_pre_rise", gpio_dat_o, 32'h0);
    idle(1, 32'h00);
    chk("eclk_rise_cap", gpio_dat_o, 32'h1);
    cycle(1'b1, 32'h20, 32'h1);
    in_pad_i = 32'h0;
    idle(5, 32'h00);
    chk("nec_hold", gpio_dat_o, 32'h1);
    gpio_eclk = 1'b0;
    idle(3, 32'h00);
    chk("nec_fall_cap", gpio_dat_o, 32'h0);

    // Asynchronous reset with an interrupt pending
    cycle(1'b1, 32'h1C, 32'h0);
    cycle(1'b1, 32'h10, 32'h1);
    in_pad_i = 32'h1;
    idle(4, 32'h04);
    chk("pre_rst_inta", {31'b0, gpio_inta_o}, 32'h1);
    chk("pre_rst_pad", out_pad_o, 32'hAAAAAAAA);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_inta", {31'b0, gpio_inta_o}, 32'h0);
    chk("arst_pad", out_pad_o, 32'h0);
    chk("arst_oen", oen_padoe_o, 32'h0);
    chk("arst_dat", gpio_dat_o, 32'h0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    model_reset();

    // Randomized traffic against the model
    cycle(1'b1, 32'h0C, $urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in_pad_i = $urandom;
      if ($urandom_range(0, 2) == 0) gpio_eclk = ~gpio_eclk;
      aux_i = $urandom;
      r = $urandom;
      cycle($urandom_range(0, 1) == 1, {r[31:8], 8'($urandom_range(0, 10) * 4)}, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
